// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_sequencer_if                                            |
// | Purpose : Bundles the fetch sequencer's signals: program-counter     |
// |           link, instruction-fetch handshake, issue handshake to      |
// |           decode, execute sideband (redirect/trap/mret) and the      |
// |           trap CSR outputs.                                          |
// | Modports: master - the sequencer (drives pc_next, imem_req,          |
// |                    instr_valid, mepc, mcause, trap_taken)            |
// |           slave  - the surrounding pipeline/program counter          |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface pc_sequencer_if;
  logic [31:0] pc;
  logic        pc_fault;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        imem_ack;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_req;
  logic [3:0]  trap_cause_in;
  logic        mret;
  logic [31:0] mepc;
  logic [3:0]  mcause;
  logic        trap_taken;

  modport master (
    input  pc, pc_fault, imem_ack, instr_ready, redirect_valid,
           redirect_target, trap_req, trap_cause_in, mret,
    output pc_next, imem_req, instr_valid, mepc, mcause, trap_taken
  );

  modport slave (
    output pc, pc_fault, imem_ack, instr_ready, redirect_valid,
           redirect_target, trap_req, trap_cause_in, mret,
    input  pc_next, imem_req, instr_valid, mepc, mcause, trap_taken
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pc_sequencer                                               |
// | Purpose : Fetch sequencer. Each cycle it selects the program         |
// |           counter's next value (hold, +4, redirect, trap vector or   |
// |           mret return), runs the fetch and issue handshakes and      |
// |           records mepc/mcause on trap entry (including misaligned    |
// |           PC faults reported by the program counter).                |
// | Ports   : clk   - clock                                              |
// |           reset - synchronous, active-high reset                     |
// |           bus   - pc_sequencer_if.master (pc link, imem handshake,   |
// |                   issue handshake, sideband, mepc/mcause/trap_taken) |
// | Params  : TRAP_VECTOR - PC loaded on any trap (4-byte aligned)       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0010
) (
  input  wire logic       clk,
  input  wire logic       reset,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_mepc;
  logic [3:0]  r_mcause;

  // Sideband inputs only matter on the cycle decode accepts the instruction.
  logic w_issue_fire;
  assign w_issue_fire = (r_state == ISSUE) && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= FETCH;
      r_mepc   <= 32'd0;
      r_mcause <= 4'd0;
    end else begin
      case (r_state)
        FETCH: begin
          // A misaligned PC is never fetched; it traps as cause 0.
          if (bus.pc_fault) begin
            r_mepc   <= bus.pc;
            r_mcause <= 4'd0;
            r_state  <= TRAP;
          end else if (bus.imem_ack) begin
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_issue_fire) begin
            if (bus.trap_req) begin
              r_mepc   <= bus.pc;
              r_mcause <= bus.trap_cause_in;
              r_state  <= TRAP;
            end else begin
              r_state  <= FETCH;
            end
          end
        end
        TRAP:    r_state <= FETCH;
        default: r_state <= FETCH;
      endcase
    end
  end

  // Outputs are forced quiet while reset is asserted, whatever the state.
  always_comb begin
    bus.pc_next     = bus.pc;
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
    bus.trap_taken  = 1'b0;
    if (reset) begin
      bus.pc_next = 32'd0;
    end else begin
      case (r_state)
        FETCH: bus.imem_req = ~bus.pc_fault;
        ISSUE: begin
          bus.instr_valid = 1'b1;
          // trap_req > mret > redirect > sequential; a trap holds the PC.
          if (w_issue_fire && !bus.trap_req) begin
            if (bus.mret)                bus.pc_next = r_mepc;
            else if (bus.redirect_valid) bus.pc_next = bus.redirect_target;
            else                         bus.pc_next = bus.pc + 32'd4;
          end
        end
        TRAP: begin
          bus.pc_next    = TRAP_VECTOR;
          bus.trap_taken = 1'b1;
        end
        default: bus.pc_next = bus.pc;
      endcase
    end
  end

  assign bus.mepc   = r_mepc;
  assign bus.mcause = r_mcause;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pc_sequencer                                            |
// | Purpose : Self-checking bench for pc_sequencer. The bench owns the   |
// |           program counter register (pc <= pc_next) and a reference   |
// |           model of the fetch/issue/trap rules that is compared with  |
// |           the DUT every cycle, plus hand-computed spot checks.       |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam logic [31:0] C_TRAP_VECTOR = 32'h0000_0010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();

  pc_sequencer #(.TRAP_VECTOR(C_TRAP_VECTOR)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Program counter: registers pc_next every cycle, flags misalignment.
  always @(posedge clk) bus.pc <= bus.pc_next;
  assign bus.pc_fault = bus.pc[1] | bus.pc[0];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = waiting for a fetch, 1 = instruction on offer to decode,
  //        2 = vectoring to the trap handler.
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [3:0]  m_cause;
  bit          cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] e_next;
      logic        e_req, e_valid, e_trap;
      int          n_phase;
      e_next  = m_pc;
      e_req   = 1'b0;
      e_valid = 1'b0;
      e_trap  = 1'b0;
      n_phase = m_phase;
      check("pc", bus.pc, m_pc);
      check("mepc", bus.mepc, m_epc);
      check("mcause", {28'd0, bus.mcause}, {28'd0, m_cause});
      if (reset) begin
        e_next  = 32'd0;
        n_phase = 0;
      end else if (m_phase == 0) begin
        if (m_pc % 4 != 0) begin
          m_epc   = m_pc;
          m_cause = 4'd0;
          n_phase = 2;
        end else begin
          e_req = 1'b1;
          if (bus.imem_ack) n_phase = 1;
        end
      end else if (m_phase == 1) begin
        e_valid = 1'b1;
        if (bus.instr_ready) begin
          n_phase = 0;
          if (bus.trap_req) begin
            m_epc   = m_pc;
            m_cause = bus.trap_cause_in;
            n_phase = 2;
          end else if (bus.mret)           e_next = m_epc;
          else if (bus.redirect_valid)     e_next = bus.redirect_target;
          else                             e_next = m_pc + 32'd4;
        end
      end else begin
        e_next  = C_TRAP_VECTOR;
        e_trap  = 1'b1;
        n_phase = 0;
      end
      if (reset) begin
        m_epc   = 32'd0;
        m_cause = 4'd0;
      end
      check("pc_next", bus.pc_next, e_next);
      check("imem_req", {31'd0, bus.imem_req}, {31'd0, e_req});
      check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, e_valid});
      check("trap_taken", {31'd0, bus.trap_taken}, {31'd0, e_trap});
      m_phase = n_phase;
      m_pc    = e_next;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset               = 1'b1;
    bus.imem_ack        = 1'b0;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'd0;
    bus.trap_req        = 1'b0;
    bus.trap_cause_in   = 4'd0;
    bus.mret            = 1'b0;
    m_phase = 0;
    m_pc    = 32'd0;
    m_epc   = 32'd0;
    m_cause = 4'd0;

    step();
    cmp_en = 1'b1;
    step();
    check("reset_pc", bus.pc, 32'h0);
    check("reset_mepc", bus.mepc, 32'h0);
    reset = 1'b0;

    // 1: back-to-back with immediate ack and ready
    bus.imem_ack    = 1'b1;
    bus.instr_ready = 1'b1;
    step_n(4);
    check("seq_pc8", bus.pc, 32'h8);
    check("seq_req", {31'd0, bus.imem_req}, 32'd1);

    // 2: stalled fetch, then stalled issue with sideband noise ignored
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b0;
    step_n(3);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'h0000_0500;
    bus.trap_req       = 1'b1;
    step_n(2);
    bus.redirect_valid = 1'b0;
    bus.trap_req       = 1'b0;
    bus.instr_ready    = 1'b1;
    step();
    check("stall_pc12", bus.pc, 32'hC);

    // 3: redirect to 0x20 then 0x100; trap beats redirect
    bus.imem_ack        = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h20;
    step_n(2);
    check("redir_pc20", bus.pc, 32'h20);
    bus.redirect_target = 32'h100;
    step_n(2);
    check("redir_pc100", bus.pc, 32'h100);
    bus.trap_req      = 1'b1;
    bus.trap_cause_in = 4'd3;
    step_n(2);
    check("prio_mepc", bus.mepc, 32'h100);
    check("prio_mcause", {28'd0, bus.mcause}, 32'd3);
    check("prio_trap_taken", {31'd0, bus.trap_taken}, 32'd1);
    bus.trap_req       = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    check("vector_pc", bus.pc, 32'h10);

    // 4: misaligned redirect traps from FETCH without a request
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h102;
    step_n(2);
    bus.redirect_valid = 1'b0;
    check("misal_pc", bus.pc, 32'h102);
    check("misal_req", {31'd0, bus.imem_req}, 32'd0);
    step();
    check("misal_mepc", bus.mepc, 32'h102);
    check("misal_mcause", {28'd0, bus.mcause}, 32'd0);
    check("misal_trap_taken", {31'd0, bus.trap_taken}, 32'd1);
    step();
    check("misal_vec", bus.pc, 32'h10);
    check("misal_pulse_end", {31'd0, bus.trap_taken}, 32'd0);

    // 5: trap cause 11 at 0x40, mret from handler returns to 0x40
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    step_n(2);
    bus.redirect_valid = 1'b0;
    bus.trap_req       = 1'b1;
    bus.trap_cause_in  = 4'd11;
    step_n(2);
    bus.trap_req = 1'b0;
    check("trap_mepc", bus.mepc, 32'h40);
    check("trap_mcause", {28'd0, bus.mcause}, 32'd11);
    step();
    check("trap_vec", bus.pc, 32'h10);
    bus.mret = 1'b1;
    step_n(2);
    bus.mret = 1'b0;
    check("mret_pc", bus.pc, 32'h40);

    // 6: reset during ISSUE, reset during stalled FETCH, PC wrap
    step();
    bus.instr_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_issue_pc", bus.pc, 32'h0);
    check("rst_issue_mepc", bus.mepc, 32'h0);
    check("rst_issue_mcause", {28'd0, bus.mcause}, 32'd0);
    bus.imem_ack = 1'b0;
    step_n(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_fetch_pc", bus.pc, 32'h0);
    bus.imem_ack        = 1'b1;
    bus.instr_ready     = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    step_n(2);
    bus.redirect_valid = 1'b0;
    check("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    step_n(2);
    check("wrap_pc0", bus.pc, 32'h0);
    step_n(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
